// File: rtl/game_score_hud.sv
// Game-state controller (IDLE/PLAY/WIN/LOSE) with a 3-digit BCD score
// rendered as a seven-segment overlay on the VGA raster.
module game_score_hud #(
   parameter int X0          = 8,
   parameter int Y0          = 8,
   parameter int PITCH       = 16,
   parameter int BLINK_TICKS = 4,
   parameter int HOLD_TICKS  = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       fire,
   input  logic       killingAlien,
   input  logic       victory,
   input  logic       defeat,
   input  logic [9:0] hPos,
   input  logic [9:0] vPos,
   output logic [1:0] state,
   output logic [11:0] score,
   output logic       restart,
   output logic [2:0] colorScore
);

   localparam int TW = $clog2(HOLD_TICKS + 1);
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [9:0] OX2 = 10'(X0);
   localparam logic [9:0] OX1 = 10'(X0 + PITCH);
   localparam logic [9:0] OX0 = 10'(X0 + 2 * PITCH);
   localparam logic [9:0] OY  = 10'(Y0);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_WIN  = 2'b10,
      S_LOSE = 2'b11
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_fire_q;
   logic            r_kill_q;
   logic [11:0]     r_score;
   logic [TW-1:0]   r_tick;
   logic [BW-1:0]   r_bcnt;
   logic            r_blink;
   logic            r_restart;
   logic [2:0]      r_color;

   logic            w_fire_rise;
   logic            w_kill_rise;
   logic            w_hold_done;
   logic            w_enter_end;
   logic            w_restart_d;
   logic            w_count_kill;
   logic [11:0]     w_score_inc;
   logic [2:0]      w_color;
   logic [9:0]      w_lx2, w_lx1, w_lx0, w_ly;
   logic            w_show2, w_show1, w_pix;

   assign w_fire_rise = fire & ~r_fire_q;
   assign w_kill_rise = killingAlien & ~r_kill_q;
   assign w_hold_done = (r_tick == TW'(HOLD_TICKS));

   // segment layout {a,b,c,d,e,f,g} tested against the 12x20 cell
   function automatic logic seg_hit(input logic [3:0] d, input logic [9:0] lx,
                                    input logic [9:0] ly);
      logic [6:0] s;
      logic       hit;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      hit = 1'b0;
      if (lx < 10'd12 && ly < 10'd20) begin
         hit = (s[6] && ly <= 10'd1)
            || (s[5] && lx >= 10'd10 && ly <= 10'd10)
            || (s[4] && lx >= 10'd10 && ly >= 10'd9)
            || (s[3] && ly >= 10'd18)
            || (s[2] && lx <= 10'd1 && ly >= 10'd9)
            || (s[1] && lx <= 10'd1 && ly <= 10'd10)
            || (s[0] && ly >= 10'd9 && ly <= 10'd10);
      end
      return hit;
   endfunction

   // state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_fire_rise) w_state_next = S_PLAY;
         S_PLAY: begin
            if (defeat)       w_state_next = S_LOSE;
            else if (victory) w_state_next = S_WIN;
         end
         default: if (w_hold_done && w_fire_rise) w_state_next = S_IDLE;
      endcase
   end

   // output / control decode
   always_comb begin
      w_enter_end  = (r_state == S_PLAY) && w_state_next[1];
      w_restart_d  = r_state[1] && (w_state_next == S_IDLE);
      w_count_kill = (r_state == S_PLAY) && w_kill_rise;
      case (r_state)
         S_WIN:   w_color = r_blink ? 3'b010 : 3'b000;
         S_LOSE:  w_color = r_blink ? 3'b100 : 3'b000;
         default: w_color = 3'b111;
      endcase
   end

   // saturating BCD increment with ripple carry
   always_comb begin
      w_score_inc = r_score;
      if (r_score != 12'h999) begin
         if (r_score[3:0] != 4'd9) begin
            w_score_inc[3:0] = r_score[3:0] + 4'd1;
         end else begin
            w_score_inc[3:0] = '0;
            if (r_score[7:4] != 4'd9) begin
               w_score_inc[7:4] = r_score[7:4] + 4'd1;
            end else begin
               w_score_inc[7:4]  = '0;
               w_score_inc[11:8] = r_score[11:8] + 4'd1;
            end
         end
      end
   end

   // local coordinates wrap to large values when left of / above a cell
   always_comb begin
      w_lx2   = hPos - OX2;
      w_lx1   = hPos - OX1;
      w_lx0   = hPos - OX0;
      w_ly    = vPos - OY;
      w_show2 = (r_score[11:8] != 4'd0);
      w_show1 = w_show2 || (r_score[7:4] != 4'd0);
      w_pix   = (w_show2 && seg_hit(r_score[11:8], w_lx2, w_ly))
             || (w_show1 && seg_hit(r_score[7:4], w_lx1, w_ly))
             || seg_hit(r_score[3:0], w_lx0, w_ly);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fire_q  <= 1'b0;
         r_kill_q  <= 1'b0;
         r_score   <= '0;
         r_tick    <= '0;
         r_bcnt    <= '0;
         r_blink   <= 1'b0;
         r_restart <= 1'b0;
         r_color   <= '0;
      end else begin
         r_fire_q  <= fire;
         r_kill_q  <= killingAlien;
         r_restart <= w_restart_d;
         r_color   <= w_pix ? w_color : 3'b000;

         if (w_restart_d)       r_score <= '0;
         else if (w_count_kill) r_score <= w_score_inc;

         if (w_enter_end) begin
            r_tick  <= '0;
            r_bcnt  <= '0;
            r_blink <= 1'b1;
         end else if (r_state[1] && enable) begin
            if (!w_hold_done) r_tick <= r_tick + TW'(1);
            if (r_bcnt == BW'(BLINK_TICKS - 1)) begin
               r_bcnt  <= '0;
               r_blink <= ~r_blink;
            end else begin
               r_bcnt <= r_bcnt + BW'(1);
            end
         end
      end
   end

   assign state      = r_state;
   assign score      = r_score;
   assign restart    = r_restart;
   assign colorScore = r_color;

endmodule

// File: tb/tb_game_score_hud.sv
// Directed, self-checking bench for game_score_hud: state flow, BCD scoring,
// hold/blink timing and seven-segment overlay geometry.
module tb_game_score_hud;

   logic       clk = 1'b0;
   logic       reset, enable, fire, killingAlien, victory, defeat;
   logic [9:0] hPos, vPos;
   logic [1:0] state;
   logic [11:0] score;
   logic       restart;
   logic [2:0] colorScore;

   int checks   = 0;
   int failures = 0;
   int nk       = 0;

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic [2:0] col;
   } geo_vec_t;

   geo_vec_t geo[18];

   always #5 clk = ~clk;

   game_score_hud #(
      .X0(8), .Y0(8), .PITCH(16), .BLINK_TICKS(4), .HOLD_TICKS(30)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .fire(fire),
      .killingAlien(killingAlien), .victory(victory), .defeat(defeat),
      .hPos(hPos), .vPos(vPos), .state(state), .score(score),
      .restart(restart), .colorScore(colorScore)
   );

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         enable = 1'b1; cyc(1);
         enable = 1'b0; cyc(1);
      end
   endtask

   task automatic kill_once(input int hi);
      killingAlien = 1'b1; cyc(hi);
      killingAlien = 1'b0; cyc(1);
      nk++;
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      int s;
      s = (v > 999) ? 999 : v;
      return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   initial begin
      // score 012: hundreds blank, tens '1' (b,c), units '2' (a,b,d,e,g)
      geo[0]  = '{10'd34, 10'd8,  3'b111};  // tens b
      geo[1]  = '{10'd34, 10'd23, 3'b111};  // tens c
      geo[2]  = '{10'd24, 10'd23, 3'b000};  // tens e unlit
      geo[3]  = '{10'd8,  10'd8,  3'b000};  // blanked hundreds
      geo[4]  = '{10'd40, 10'd8,  3'b111};  // units a, left edge
      geo[5]  = '{10'd51, 10'd8,  3'b111};  // units a, right edge
      geo[6]  = '{10'd52, 10'd8,  3'b000};  // one past cell
      geo[7]  = '{10'd39, 10'd8,  3'b000};  // lx wraps negative
      geo[8]  = '{10'd40, 10'd7,  3'b000};  // ly wraps negative
      geo[9]  = '{10'd40, 10'd13, 3'b000};  // f unlit
      geo[10] = '{10'd50, 10'd13, 3'b111};  // b lit
      geo[11] = '{10'd40, 10'd23, 3'b111};  // e lit
      geo[12] = '{10'd50, 10'd23, 3'b000};  // c unlit
      geo[13] = '{10'd45, 10'd17, 3'b111};  // g top row
      geo[14] = '{10'd45, 10'd13, 3'b000};  // cell interior
      geo[15] = '{10'd45, 10'd27, 3'b111};  // d bottom row
      geo[16] = '{10'd45, 10'd28, 3'b000};  // below cell
      geo[17] = '{10'd41, 10'd18, 3'b111};  // g/f/e overlap column

      reset = 1'b0; enable = 1'b0; fire = 1'b0; killingAlien = 1'b0;
      victory = 1'b0; defeat = 1'b0; hPos = '0; vPos = '0;
      cyc(3);
      chk("rst_state", 12'(state), 12'h0);
      chk("rst_score", score, 12'h000);
      chk("rst_restart", 12'(restart), 12'h0);
      chk("rst_color", 12'(colorScore), 12'h0);
      reset = 1'b1; cyc(1);
      chk("idle_state", 12'(state), 12'h0);

      fire = 1'b1; cyc(1);
      chk("fire_to_play", 12'(state), 12'h1);
      cyc(2); fire = 1'b0; cyc(1);
      chk("play_hold", 12'(state), 12'h1);
      chk("play_score0", score, 12'h000);

      for (int i = 0; i < 12; i++) kill_once(3);
      chk("score_012", score, to_bcd(nk));

      hPos = 10'd34; vPos = 10'd8; #1;
      chk("color_latency", 12'(colorScore), 12'h0);
      cyc(1);
      chk("color_tens_b", 12'(colorScore), 12'h7);

      for (int i = 0; i < 18; i++) begin
         hPos = geo[i].h; vPos = geo[i].v;
         cyc(1);
         chk($sformatf("geo_%0d", i), 12'(colorScore), 12'(geo[i].col));
      end
      hPos = '0; vPos = '0;

      while (nk < 99) begin
         kill_once(1);
         chk("score_ramp", score, to_bcd(nk));
      end
      chk("score_099", score, 12'h099);
      kill_once(1);
      chk("score_100", score, 12'h100);
      while (nk < 999) begin
         kill_once(1);
         chk("score_ramp", score, to_bcd(nk));
      end
      chk("score_999", score, 12'h999);
      kill_once(1);
      chk("score_sat", score, 12'h999);

      hPos = 10'd40; vPos = 10'd8;
      victory = 1'b1; defeat = 1'b1; cyc(1);
      chk("defeat_prio", 12'(state), 12'h3);
      chk("lose_score", score, 12'h999);
      chk("color_play_last", 12'(colorScore), 12'h7);
      victory = 1'b0; defeat = 1'b0; cyc(1);
      chk("lose_stays", 12'(state), 12'h3);
      chk("lose_blink_on", 12'(colorScore), 12'h4);
      killingAlien = 1'b1; cyc(1);
      chk("lose_kill_ign", score, 12'h999);
      killingAlien = 1'b0; cyc(1);

      tick(10);
      chk("blink_t10", 12'(colorScore), 12'h4);
      fire = 1'b1; cyc(1);
      chk("fire_t10_state", 12'(state), 12'h3);
      chk("fire_t10_rst", 12'(restart), 12'h0);
      fire = 1'b0; cyc(1);
      tick(2);
      chk("blink_t12", 12'(colorScore), 12'h0);
      tick(17);
      fire = 1'b1; cyc(1);
      chk("fire_t29_state", 12'(state), 12'h3);
      fire = 1'b0; cyc(1);
      tick(1);
      chk("no_queue", 12'(state), 12'h3);
      chk("blink_t30", 12'(colorScore), 12'h0);
      tick(3);
      chk("blink_t33", 12'(colorScore), 12'h4);
      fire = 1'b1; cyc(1);
      chk("restart_state", 12'(state), 12'h0);
      chk("restart_score", score, 12'h000);
      chk("restart_pulse", 12'(restart), 12'h1);
      cyc(1);
      chk("restart_clear", 12'(restart), 12'h0);
      chk("idle_held_fire", 12'(state), 12'h0);
      fire = 1'b0; cyc(1);
      chk("restart_low", 12'(restart), 12'h0);
      chk("idle_units0", 12'(colorScore), 12'h7);

      fire = 1'b1; cyc(1);
      chk("replay", 12'(state), 12'h1);
      fire = 1'b0; victory = 1'b1; killingAlien = 1'b1; cyc(1);
      chk("win_state", 12'(state), 12'h2);
      chk("win_kill_count", score, 12'h001);
      victory = 1'b0; killingAlien = 1'b0; hPos = 10'd50; vPos = 10'd8; cyc(1);
      chk("win_blink_on", 12'(colorScore), 12'h2);
      killingAlien = 1'b1; cyc(1);
      chk("win_kill_ign", score, 12'h001);
      killingAlien = 1'b0; cyc(1);
      tick(4);
      chk("win_blink_off", 12'(colorScore), 12'h0);
      tick(4);
      chk("win_blink_on2", 12'(colorScore), 12'h2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
